mc_sequencer: RTL and testbench

Single-clock, synchronous replacement for the request/acknowledge pipeline that couples program memory, program counter, logic unit and I/O in the MC14500-style controller. It fetches instructions, executes the full 16-opcode set internally (RR, IEN, OEN, skip), and talks to program memory and I/O over valid/ready-style bus handshakes. Unlike the original chain, JMP pushes a return address onto a parametrised call stack and RTN pops it, which gives the design real subroutines.

---
 rtl/mc_sequencer_pkg.sv | 35 +++
 rtl/mc_sequencer_call_stack.sv | 45 ++++
 rtl/mc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_sequencer_pkg.sv
// Shared opcode and sequencer-state definitions for the MC14500-style controller.
package mc_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } instruction_t;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t S_IDLE  = 2'd0;
  localparam seq_state_t S_FETCH = 2'd1;
  localparam seq_state_t S_EXEC  = 2'd2;
  localparam seq_state_t S_IO    = 2'd3;

  // Opcodes that consume a one-bit operand from I/O (or from RR at the all-ones address).
  function automatic logic is_read_op(input instruction_t op);
    return op inside {[OP_LD:OP_XNOR], OP_IEN, OP_OEN};
  endfunction

endpackage

// File: rtl/mc_sequencer_call_stack.sv
// Return-address LIFO; entry 0 is always the top, so no pointer-indexed reads are needed.
module call_stack #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [DATA_W-1:0] mem [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt;

  assign full  = (cnt == CNT_W'(STACK_DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[0] <= din;
      for (int i = 1; i < STACK_DEPTH; i++) mem[i] <= mem[i-1];
    end else if (pop && !empty) begin
      for (int i = 1; i < STACK_DEPTH; i++) mem[i-1] <= mem[i];
    end
  end

  push_pop_exclusive: assert property (@(posedge clk) disable iff (reset) !(push && pop));

endmodule

// File: rtl/mc_sequencer.sv
// Fetch/execute sequencer for the 16-opcode one-bit controller with a hardware call stack.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  prog_req,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_valid,
  output logic                  io_rd,
  output logic                  io_wr,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic                  io_wdata,
  input  logic                  io_rdata,
  input  logic                  io_ack,
  output logic                  rr_out,
  output logic                  flag_o,
  output logic                  flag_f,
  output logic                  stack_err,
  output logic                  halted
);
  seq_state_t            state;
  seq_state_t            boundary;
  instruction_t          ir_op;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [ADDR_WIDTH-1:0] stack_dout;
  logic                  rr;
  logic                  ien;
  logic                  oen;
  logic                  skip;
  logic                  addr_ones;
  logic                  exec_live;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;

  // Returns the updated {rr, ien, oen} for an operand-consuming opcode.
  function automatic logic [2:0] exec_read(input instruction_t op, input logic rr_q,
                                           input logic ien_q, input logic oen_q,
                                           input logic raw);
    logic       d;
    logic [2:0] r;
    d = ien_q & raw;
    r = {rr_q, ien_q, oen_q};
    case (op)
      OP_LD:   r[2] = d;
      OP_LDC:  r[2] = ~d;
      OP_AND:  r[2] = rr_q & d;
      OP_ANDC: r[2] = rr_q & ~d;
      OP_OR:   r[2] = rr_q | d;
      OP_ORC:  r[2] = rr_q | ~d;
      OP_XNOR: r[2] = ~(rr_q ^ d);
      OP_IEN:  r[1] = raw;
      OP_OEN:  r[0] = raw;
      default: ;
    endcase
    return r;
  endfunction

  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign addr_ones = &ir_addr;
  assign boundary  = run ? S_FETCH : S_IDLE;
  assign exec_live = (state == S_EXEC) && !skip;
  assign push      = exec_live && (ir_op == OP_JMP) && !full;
  assign pop       = exec_live && (ir_op == OP_RTN) && !empty;

  assign prog_req  = (state == S_FETCH);
  assign prog_addr = pc;
  assign rr_out    = rr;
  assign halted    = (state == S_IDLE);

  call_stack #(
    .DATA_W      (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stack_dout),
    .full  (full),
    .empty (empty)
  );

  // Instruction register is pure data and only meaningful after a fetch.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && prog_valid) begin
      ir_op   <= instruction_t'(prog_data[DATA_WIDTH-1 -: INSTRUCTION_WIDTH]);
      ir_addr <= prog_data[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      rr        <= 1'b0;
      ien       <= 1'b0;
      oen       <= 1'b0;
      skip      <= 1'b0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= 1'b0;
      flag_o    <= 1'b0;
      flag_f    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      flag_o    <= 1'b0;
      flag_f    <= 1'b0;
      stack_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (prog_valid) state <= S_EXEC;
        end
        S_EXEC: begin
          if (skip) begin
            skip  <= 1'b0;
            pc    <= pc_inc;
            state <= boundary;
          end else if (is_read_op(ir_op)) begin
            if (!addr_ones) begin
              io_rd   <= 1'b1;
              io_addr <= ir_addr;
              state   <= S_IO;
            end else begin
              {rr, ien, oen} <= exec_read(ir_op, rr, ien, oen, rr);
              pc    <= pc_inc;
              state <= boundary;
            end
          end else begin
            case (ir_op)
              OP_STO, OP_STOC: begin
                if (oen && !addr_ones) begin
                  io_wr    <= 1'b1;
                  io_addr  <= ir_addr;
                  io_wdata <= (ir_op == OP_STO) ? rr : ~rr;
                  state    <= S_IO;
                end else begin
                  pc    <= pc_inc;
                  state <= boundary;
                end
              end
              OP_JMP: begin
                // A full stack drops the return address but the jump still happens.
                stack_err <= full;
                pc        <= ir_addr;
                state     <= boundary;
              end
              OP_RTN: begin
                stack_err <= empty;
                pc        <= empty ? pc_inc : stack_dout;
                state     <= boundary;
              end
              OP_SKZ: begin
                skip  <= ~rr;
                pc    <= pc_inc;
                state <= boundary;
              end
              OP_NOPO: begin
                flag_o <= 1'b1;
                pc     <= pc_inc;
                state  <= boundary;
              end
              OP_NOPF: begin
                flag_f <= 1'b1;
                pc     <= pc_inc;
                state  <= boundary;
              end
              default: begin
                pc    <= pc_inc;
                state <= boundary;
              end
            endcase
          end
        end
        S_IO: begin
          if (io_ack) begin
            if (io_rd) {rr, ien, oen} <= exec_read(ir_op, rr, ien, oen, io_rdata);
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            pc    <= pc_inc;
            state <= boundary;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scenario bench for mc_sequencer: bus responders log events, each test compares them to its expectations.
module tb_mc_sequencer;
  import mc_sequencer_pkg::*;

  typedef struct {
    byte        kind;
    logic [7:0] addr;
    logic       data;
    int         cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        prog_req;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data = '0;
  logic        prog_valid = 1'b0;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_addr;
  logic        io_wdata;
  logic        io_rdata = 1'b0;
  logic        io_ack = 1'b0;
  logic        rr_out;
  logic        flag_o;
  logic        flag_f;
  logic        stack_err;
  logic        halted;

  logic [11:0] prog_mem [256];
  logic        io_mem [256];
  int          io_lat = 1;
  int          cyc = 0;
  int          pcnt = 0;
  int          icnt = 0;
  int          n_pass = 0;
  int          n_total = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  mc_sequencer #(.STACK_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .prog_req   (prog_req),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_ack     (io_ack),
    .rr_out     (rr_out),
    .flag_o     (flag_o),
    .flag_f     (flag_f),
    .stack_err  (stack_err),
    .halted     (halted)
  );

  initial forever #5 clk = ~clk;

  // Memory and I/O responders plus the observed-event log, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    prog_valid = 1'b0;
    io_ack     = 1'b0;
    if (reset) begin
      pcnt = 0;
      icnt = 0;
    end else begin
      if (stack_err) obs_q.push_back('{kind: "E", addr: 8'h00, data: 1'b0, cyc: cyc});
      if (flag_o)    obs_q.push_back('{kind: "O", addr: 8'h00, data: 1'b0, cyc: cyc});
      if (flag_f)    obs_q.push_back('{kind: "P", addr: 8'h00, data: 1'b0, cyc: cyc});
      if (prog_req) begin
        if (pcnt == 1) begin
          prog_valid = 1'b1;
          prog_data  = prog_mem[prog_addr];
          obs_q.push_back('{kind: "F", addr: prog_addr, data: 1'b0, cyc: cyc});
          pcnt = 0;
        end else pcnt++;
      end else pcnt = 0;
      if (io_rd || io_wr) begin
        if (icnt == io_lat) begin
          io_ack = 1'b1;
          if (io_rd) begin
            io_rdata = io_mem[io_addr];
            obs_q.push_back('{kind: "R", addr: io_addr, data: io_mem[io_addr], cyc: cyc});
          end else begin
            obs_q.push_back('{kind: "W", addr: io_addr, data: io_wdata, cyc: cyc});
          end
          icnt = 0;
        end else icnt++;
      end else icnt = 0;
    end
  end

  function automatic logic [11:0] ins(input instruction_t op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic ex(input byte k, input logic [7:0] a, input logic d);
    exp_q.push_back('{kind: k, addr: a, data: d, cyc: 0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    io_lat = 1;
    for (int i = 0; i < 256; i++) prog_mem[i] = ins(OP_OR, 8'hFF);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Runs until the nth fetch request at stop, lets that instruction finish, then waits for idle.
  task automatic run_until(input logic [7:0] stop, input int nth);
    int seen = 0;
    int t = 0;
    bit prev = 1'b0;
    @(negedge clk);
    run = 1'b1;
    while (seen < nth && t < 3000) begin
      @(negedge clk);
      t++;
      if (prog_req && !prev && prog_addr == stop) seen++;
      prev = prog_req;
    end
    run = 1'b0;
    while (!halted && t < 3200) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (seen < nth || !halted) $display("FAIL run_timeout stop=%h seen %0d halted %b, required %0d and 1", stop, seen, halted, nth);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({prog_req, prog_addr, io_rd, io_wr, io_addr, io_wdata, rr_out, flag_o, flag_f, stack_err, halted}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_outputs got req=%b pa=%h rd=%b wr=%b ia=%h wd=%b rr=%b fo=%b ff=%b se=%b h=%b",
               prog_req, prog_addr, io_rd, io_wr, io_addr, io_wdata, rr_out, flag_o, flag_f, stack_err, halted);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({halted, prog_req} !== 2'b10) $display("FAIL idle_hold got halted=%b req=%b want 1 0", halted, prog_req);
    else n_pass++;
  endtask

  task automatic test_store();
    ev_t e, o;
    int  k = 0;
    int  d;
    do_reset();
    prog_mem[0] = ins(OP_IEN, 8'h01);
    prog_mem[1] = ins(OP_OEN, 8'h01);
    prog_mem[2] = ins(OP_LD, 8'h01);
    prog_mem[3] = ins(OP_STO, 8'h02);
    ex("F", 8'h00, 0); ex("R", 8'h01, 1); ex("F", 8'h01, 0); ex("R", 8'h01, 1);
    ex("F", 8'h02, 0); ex("R", 8'h01, 1); ex("F", 8'h03, 0); ex("W", 8'h02, 1); ex("F", 8'h04, 0);
    run_until(8'h04, 1);
    d = (obs_q.size() >= 3) ? obs_q[2].cyc - obs_q[0].cyc : -1;
    n_total++;
    if (d != 5) $display("FAIL io_instr_cycles got %0d want 5", d);
    else n_pass++;
    n_total++;
    if (rr_out !== 1'b1) $display("FAIL store_rr got %b want 1", rr_out);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL store_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL store_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
    // Input enable left at 0: LD is gated to 0 so the stored bit is 0.
    do_reset();
    k = 0;
    prog_mem[0] = ins(OP_OEN, 8'h01);
    prog_mem[1] = ins(OP_LD, 8'h01);
    prog_mem[2] = ins(OP_STO, 8'h02);
    ex("F", 8'h00, 0); ex("R", 8'h01, 1); ex("F", 8'h01, 0); ex("R", 8'h01, 1);
    ex("F", 8'h02, 0); ex("W", 8'h02, 0); ex("F", 8'h03, 0);
    run_until(8'h03, 1);
    n_total++;
    if (rr_out !== 1'b0) $display("FAIL ien0_rr got %b want 0", rr_out);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL ien0_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL ien0_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_jmp_rtn();
    ev_t e, o;
    int  k = 0;
    int  d;
    do_reset();
    prog_mem[3]     = ins(OP_NOPF, 8'h00);
    prog_mem[5]     = ins(OP_JMP, 8'h10);
    prog_mem[8'h10] = ins(OP_RTN, 8'h00);
    prog_mem[6]     = ins(OP_RTN, 8'h00);
    ex("F", 8'h00, 0); ex("F", 8'h01, 0); ex("F", 8'h02, 0); ex("F", 8'h03, 0); ex("P", 8'h00, 0);
    ex("F", 8'h04, 0); ex("F", 8'h05, 0); ex("F", 8'h10, 0); ex("F", 8'h06, 0); ex("E", 8'h00, 0);
    ex("F", 8'h07, 0);
    run_until(8'h07, 1);
    d = (obs_q.size() >= 2) ? obs_q[1].cyc - obs_q[0].cyc : -1;
    n_total++;
    if (d != 3) $display("FAIL nop_cycles got %0d want 3", d);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL jmp_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL jmp_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_stack_bounds();
    ev_t e, o;
    int  k = 0;
    do_reset();
    prog_mem[8'h00] = ins(OP_JMP, 8'h20);
    prog_mem[8'h20] = ins(OP_JMP, 8'h30);
    prog_mem[8'h30] = ins(OP_JMP, 8'h40);
    prog_mem[8'h40] = ins(OP_RTN, 8'h00);
    prog_mem[8'h21] = ins(OP_RTN, 8'h00);
    prog_mem[8'h01] = ins(OP_RTN, 8'h00);
    ex("F", 8'h00, 0); ex("F", 8'h20, 0); ex("F", 8'h30, 0); ex("E", 8'h00, 0); ex("F", 8'h40, 0);
    ex("F", 8'h21, 0); ex("F", 8'h01, 0); ex("E", 8'h00, 0); ex("F", 8'h02, 0);
    run_until(8'h02, 1);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL stack_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL stack_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_skz();
    ev_t e, o;
    int  k = 0;
    do_reset();
    prog_mem[0] = ins(OP_IEN, 8'h01);
    prog_mem[1] = ins(OP_OEN, 8'h01);
    prog_mem[2] = ins(OP_SKZ, 8'h00);
    prog_mem[3] = ins(OP_STO, 8'h03);
    prog_mem[4] = ins(OP_LD, 8'h01);
    prog_mem[5] = ins(OP_SKZ, 8'h00);
    prog_mem[6] = ins(OP_STO, 8'h03);
    ex("F", 8'h00, 0); ex("R", 8'h01, 1); ex("F", 8'h01, 0); ex("R", 8'h01, 1); ex("F", 8'h02, 0);
    ex("F", 8'h03, 0); ex("F", 8'h04, 0); ex("R", 8'h01, 1); ex("F", 8'h05, 0); ex("F", 8'h06, 0);
    ex("W", 8'h03, 1); ex("F", 8'h07, 0);
    run_until(8'h07, 1);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL skz_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL skz_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_io_delay();
    ev_t  e, o;
    int   k = 0;
    int   t = 0;
    int   hi = 0;
    logic rr_before;
    do_reset();
    io_lat = 4;
    prog_mem[0] = ins(OP_IEN, 8'h01);
    prog_mem[1] = ins(OP_LD, 8'h04);
    ex("F", 8'h00, 0); ex("R", 8'h01, 1); ex("F", 8'h01, 0); ex("R", 8'h04, 1); ex("F", 8'h02, 0);
    @(negedge clk);
    run = 1'b1;
    while (!(io_rd && io_addr == 8'h04) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (!(io_rd && io_addr == 8'h04)) $display("FAIL ld_rd_timeout got rd=%b addr=%h want 1 04", io_rd, io_addr);
    else n_pass++;
    rr_before = rr_out;
    while (io_rd && t < 500) begin
      hi++;
      @(negedge clk);
      t++;
    end
    n_total++;
    if (hi != 5) $display("FAIL rd_hold_cycles got %0d want 5", hi);
    else n_pass++;
    n_total++;
    if ({rr_before, rr_out} !== 2'b01) $display("FAIL rr_after_ack got before=%b after=%b want 0 1", rr_before, rr_out);
    else n_pass++;
    run = 1'b0;
    while (!halted && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL delay_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL delay_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_reset_in_io();
    int t = 0;
    do_reset();
    io_lat = 20;
    io_mem[5] = 1'b1;
    prog_mem[3] = ins(OP_LD, 8'h05);
    @(negedge clk);
    run = 1'b1;
    while (!io_rd && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    n_total++;
    if ({io_rd, prog_req, prog_addr, halted} !== {1'b0, 1'b0, 8'h00, 1'b1})
      $display("FAIL reset_in_io got rd=%b req=%b pa=%h halted=%b want 0 0 00 1", io_rd, prog_req, prog_addr, halted);
    else n_pass++;
    reset = 1'b0;
    repeat (25) @(negedge clk);
    n_total++;
    if ({io_rd, rr_out, halted} !== 3'b001)
      $display("FAIL post_reset_quiet got rd=%b rr=%b halted=%b want 0 0 1", io_rd, rr_out, halted);
    else n_pass++;
    io_mem[5] = 1'b0;
    io_lat = 1;
  endtask

  task automatic test_wrap();
    ev_t e, o;
    int  k = 0;
    do_reset();
    prog_mem[8'h00] = ins(OP_JMP, 8'hFF);
    prog_mem[8'hFF] = ins(OP_NOPO, 8'h00);
    ex("F", 8'h00, 0); ex("F", 8'hFF, 0); ex("O", 8'h00, 0); ex("F", 8'h00, 0);
    run_until(8'h00, 2);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wrap_len got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data)
        $display("FAIL wrap_ev%0d got %c %h %b want %c %h %b", k, o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      else n_pass++;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) io_mem[i] = 1'b0;
    io_mem[1] = 1'b1;
    io_mem[4] = 1'b1;
    test_reset();
    test_store();
    test_jmp_rtn();
    test_stack_bounds();
    test_skz();
    test_io_delay();
    test_reset_in_io();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
